// File: rtl/reg_scoreboard.sv
// Register-status scoreboard: tracks in-flight writers per architectural register and
// flags decode sources whose youngest writer has not yet produced a forwardable value.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [4:0]       issue_dst,
  input  logic [LAT_W-1:0] issue_lat,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_dst,
  input  logic             flush,
  input  logic [4:0]       q_ra1,
  input  logic [4:0]       q_ra2,
  output logic             q_busy1,
  output logic             q_busy2,
  output logic [5:0]       outstanding,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0][LAT_W-1:0] avail_q, avail_d;
  logic                       err_q, err_d;
  logic                       issue_fire, wb_hit;
  logic [5:0]                 sum_c;

  always_comb begin : next_state
    issue_ready = !(issue_regwrite && (issue_dst != '0) && (cnt_q[issue_dst] == CNT_MAX));
    issue_fire  = issue_valid && issue_regwrite && (issue_dst != '0) && issue_ready;
    wb_hit      = wb_valid && (wb_dst != '0);
    err_d       = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]   = cnt_q[r];
      avail_d[r] = (avail_q[r] != '0) ? avail_q[r] - LAT_W'(1) : '0;
      if (issue_fire && (issue_dst == 5'(r))) begin
        // youngest writer owns availability; a same-cycle retire cancels the increment
        avail_d[r] = issue_lat;
        if (!(wb_hit && (wb_dst == 5'(r))))
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wb_hit && (wb_dst == 5'(r))) begin
        if (cnt_q[r] == '0) begin
          if (!flush) err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
          if (cnt_q[r] == CNT_W'(1)) avail_d[r] = '0;
        end
      end
      if (flush || (r == 0)) begin
        cnt_d[r]   = '0;
        avail_d[r] = '0;
      end
    end
  end

  always_comb begin : total
    sum_c = '0;
    for (int r = 0; r < NREG; r++) sum_c = sum_c + 6'(cnt_q[r]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      avail_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  assign q_busy1     = (q_ra1 != '0) && (cnt_q[q_ra1] != '0) && (avail_q[q_ra1] != '0);
  assign q_busy2     = (q_ra2 != '0) && (cnt_q[q_ra2] != '0) && (avail_q[q_ra2] != '0);
  assign outstanding = sum_c;
  assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed table, hand sequences for saturation/flush/reset,
// then random traffic against a timestamp-based reference model.
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       resetn;
  logic       issue_valid, issue_regwrite, wb_valid, flush;
  logic [4:0] issue_dst, wb_dst, q_ra1, q_ra2;
  logic [3:0] issue_lat;
  logic       issue_ready, q_busy1, q_busy2, err;
  logic [5:0] outstanding;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.NREG(32), .CNT_W(2), .LAT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_dst(issue_dst), .issue_lat(issue_lat), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: pending count per register plus the absolute cycle at which the
  // youngest writer's value becomes forwardable.
  int     mcnt[32];
  longint mrdy[32];
  longint cyc = 0;
  bit     merr = 0;

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mrdy[r] = 0; end
    merr = 0;
  endfunction

  function automatic void m_step();
    int  d, w;
    bit  fire, ret;
    d = int'(issue_dst);
    w = int'(wb_dst);
    cyc++;
    if (flush) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      return;
    end
    fire = issue_valid && issue_regwrite && d != 0 && mcnt[d] < 3;
    ret  = wb_valid && w != 0;
    if (ret && !(fire && w == d)) begin
      if (mcnt[w] == 0) merr = 1;
      else mcnt[w]--;
    end
    if (fire) begin
      if (!(ret && w == d)) mcnt[d]++;
      mrdy[d] = cyc + longint'(issue_lat);
    end
  endfunction

  function automatic int m_busy(input int ra);
    return (ra != 0 && mcnt[ra] > 0 && cyc < mrdy[ra]) ? 1 : 0;
  endfunction

  function automatic int m_out();
    int s = 0;
    for (int r = 0; r < 32; r++) s += mcnt[r];
    return s % 64;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int rdy;
    rdy = (issue_regwrite && issue_dst != 0 && mcnt[issue_dst] == 3) ? 0 : 1;
    chk({tag, " ready"}, int'(issue_ready), rdy);
    chk({tag, " busy1"}, int'(q_busy1), m_busy(int'(q_ra1)));
    chk({tag, " busy2"}, int'(q_busy2), m_busy(int'(q_ra2)));
    chk({tag, " outstanding"}, int'(outstanding), m_out());
    chk({tag, " err"}, int'(err), int'(merr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) m_step();
    #1;
  endtask

  task automatic drive(input int iv, rw, dst, lat, wv, wd, fl, ra1, ra2);
    issue_valid = 1'(iv); issue_regwrite = 1'(rw); issue_dst = 5'(dst);
    issue_lat = 4'(lat); wb_valid = 1'(wv); wb_dst = 5'(wd); flush = 1'(fl);
    q_ra1 = 5'(ra1); q_ra2 = 5'(ra2);
  endtask

  typedef struct {
    int iv, rw, dst, lat, wv, wd, fl, ra1, ra2;
    int rdy, b1, b2, out, er;
  } vec_t;
  vec_t tbl[15];

  initial begin
    // each row is held for one edge; expectations are sampled after that edge
    tbl[0]  = '{1,1,5,2, 0,0,0, 5,0,  1,1,0,1,0};
    tbl[1]  = '{0,0,0,0, 0,0,0, 5,0,  1,1,0,1,0};
    tbl[2]  = '{0,0,0,0, 0,0,0, 5,0,  1,0,0,1,0};
    tbl[3]  = '{0,0,0,0, 1,5,0, 5,0,  1,0,0,0,0};
    tbl[4]  = '{1,1,7,3, 0,0,0, 7,0,  1,1,0,1,0};
    tbl[5]  = '{1,1,7,0, 0,0,0, 7,0,  1,0,0,2,0};
    tbl[6]  = '{0,0,0,0, 1,7,0, 7,0,  1,0,0,1,0};
    tbl[7]  = '{0,0,0,0, 1,7,0, 0,7,  1,0,0,0,0};
    tbl[8]  = '{1,1,0,5, 0,0,0, 0,0,  1,0,0,0,0};
    tbl[9]  = '{1,1,3,4, 0,0,0, 3,0,  1,1,0,1,0};
    tbl[10] = '{1,1,3,1, 1,3,0, 3,0,  1,1,0,1,0};
    tbl[11] = '{0,0,0,0, 0,0,0, 0,3,  1,0,0,1,0};
    tbl[12] = '{0,0,0,0, 1,4,0, 3,0,  1,0,0,1,1};
    tbl[13] = '{0,0,0,0, 1,3,0, 3,0,  1,0,0,0,1};
    tbl[14] = '{1,0,6,5, 0,0,0, 6,0,  1,0,0,0,1};

    resetn = 1'b0;
    drive(0,0,0,0, 0,0,0, 0,0);
    m_reset();
    tick(); tick();
    chk("reset ready", int'(issue_ready), 1);
    chk("reset out", int'(outstanding), 0);
    chk("reset err", int'(err), 0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].rw, tbl[i].dst, tbl[i].lat, tbl[i].wv, tbl[i].wd,
            tbl[i].fl, tbl[i].ra1, tbl[i].ra2);
      tick();
      chk($sformatf("vec%0d ready", i), int'(issue_ready), tbl[i].rdy);
      chk($sformatf("vec%0d busy1", i), int'(q_busy1), tbl[i].b1);
      chk($sformatf("vec%0d busy2", i), int'(q_busy2), tbl[i].b2);
      chk($sformatf("vec%0d out", i), int'(outstanding), tbl[i].out);
      chk($sformatf("vec%0d err", i), int'(err), tbl[i].er);
    end

    // saturate r9; ready is a function of registered state, so a retire in the same
    // cycle does not unblock an issue to a full counter
    for (int k = 0; k < 3; k++) begin drive(1,1,9,5, 0,0,0, 9,0); tick(); end
    chk("sat out", int'(outstanding), 3);
    chk("sat ready", int'(issue_ready), 0);
    drive(1,1,9,7, 1,9,0, 9,0); tick();
    chk("sat blocked out", int'(outstanding), 2);
    chk("sat blocked ready", int'(issue_ready), 1);
    drive(1,1,9,6, 1,9,0, 9,0); tick();
    chk("swap out", int'(outstanding), 2);
    chk("swap busy", int'(q_busy1), 1);
    drive(0,0,0,0, 0,0,0, 9,0);
    for (int k = 0; k < 5; k++) tick();
    chk("swap busy late", int'(q_busy1), 1);
    tick();
    chk("swap busy done", int'(q_busy1), 0);

    // flush wins over a same-cycle issue
    drive(1,1,3,4, 0,0,0, 3,6); tick();
    drive(1,1,6,4, 0,0,0, 3,6); tick();
    drive(1,1,8,4, 0,0,0, 3,8); tick();
    chk("pre-flush out", int'(outstanding), 5);
    drive(1,1,10,4, 0,0,1, 10,3); tick();
    chk("flush out", int'(outstanding), 0);
    chk("flush busy10", int'(q_busy1), 0);
    chk("flush busy3", int'(q_busy2), 0);
    chk("flush err kept", int'(err), 1);

    // asynchronous reset while r5 is busy
    drive(1,1,5,3, 0,0,0, 5,0); tick(); tick();
    drive(0,0,0,0, 0,0,0, 5,0);
    chk("prereset busy", int'(q_busy1), 1);
    chk("prereset out", int'(outstanding), 2);
    issue_regwrite = 1'b1; issue_dst = 5'd5;
    #2 resetn = 1'b0;
    #1;
    m_reset();
    chk("async busy", int'(q_busy1), 0);
    chk("async out", int'(outstanding), 0);
    chk("async ready", int'(issue_ready), 1);
    chk("async err", int'(err), 0);
    tick();
    resetn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
